// File: rtl/psum_drain_pkg.sv
// Shared configuration for the psum drain stage: sizes, requant config and vector types.
package psum_drain_pkg;

  localparam int PEROW      = 16;
  localparam int PSUMDWD    = 24;
  localparam int DWD        = 8;
  localparam int OUTN       = 4;
  localparam int DEPTH      = 4;
  localparam int PSUMOUTN   = OUTN;
  localparam int PSUMQDEPTH = DEPTH;

  localparam int BEATS = PEROW / OUTN;
  localparam int SHW   = $clog2(PSUMDWD);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef struct packed {
    logic [SHW-1:0] shift;
    logic           relu;
  } QuantConf;

  typedef logic [PEROW-1:0][PSUMDWD-1:0] psum_vec_t;
  typedef logic [OUTN-1:0][DWD-1:0]      out_beat_t;

endpackage

// File: rtl/psum_drain_if.sv
// Psum input stream, requant config and serialized output beat stream of the drain stage.
interface psum_drain_if;
  import psum_drain_pkg::*;

  logic            Psum_rdy;
  logic            Psum_ack;
  psum_vec_t       i_Psum;
  QuantConf        i_qconf;
  logic            Out_rdy;
  logic            Out_ack;
  out_beat_t       o_Out;
  logic [BW-1:0]   o_beat;
  logic            o_last;
  logic [CW-1:0]   o_count;
  logic            o_busy;

  modport master (
    output Psum_rdy, i_Psum, i_qconf, Out_ack,
    input  Psum_ack, Out_rdy, o_Out, o_beat, o_last, o_count, o_busy
  );

  modport slave (
    input  Psum_rdy, i_Psum, i_qconf, Out_ack,
    output Psum_ack, Out_rdy, o_Out, o_beat, o_last, o_count, o_busy
  );

endinterface

// File: rtl/psum_quant.sv
// One-lane requantizer: optional ReLU, round-half-up arithmetic shift, signed saturation.
module psum_quant
  import psum_drain_pkg::*;
(
  input  logic [PSUMDWD-1:0] i_psum,
  input  QuantConf           i_qconf,
  output logic [DWD-1:0]     o_out
);

  localparam int XW = PSUMDWD + 1;
  localparam logic signed [XW-1:0] QMAX = XW'((1 << (DWD - 1)) - 1);
  localparam logic signed [XW-1:0] QMIN = ~QMAX;

  logic signed [XW-1:0] w_v;
  logic signed [XW-1:0] w_rnd;
  logic signed [XW-1:0] w_sum;
  logic signed [XW-1:0] w_shr;

  // One guard bit keeps the rounding add from wrapping at full-scale positive input.
  assign w_v   = (i_qconf.relu && i_psum[PSUMDWD-1]) ? '0 : {i_psum[PSUMDWD-1], i_psum};
  assign w_rnd = (i_qconf.shift == '0) ? '0 : (XW'(1) << (i_qconf.shift - 1'b1));
  assign w_sum = w_v + w_rnd;
  assign w_shr = w_sum >>> i_qconf.shift;

  always_comb begin
    o_out = w_shr[DWD-1:0];
    if (w_shr > QMAX) begin
      o_out = QMAX[DWD-1:0];
    end else if (w_shr < QMIN) begin
      o_out = QMIN[DWD-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Vector FIFO behind the PE that serializes each buffered psum vector into requantized OUTN-lane beats.
module psum_drain
  import psum_drain_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  psum_drain_if.slave bus
);

  localparam int IW = $clog2(PEROW);

  psum_vec_t        r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [BW-1:0]    r_beat;

  logic             w_full;
  logic             w_nonempty;
  logic             w_push;
  logic             w_pop;
  logic             w_beat_xfer;
  logic             w_last;
  psum_vec_t        w_head;
  out_beat_t        w_out;

  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_nonempty  = (r_count != '0);
  assign w_last      = (r_beat == BW'(BEATS - 1));
  assign w_beat_xfer = w_nonempty && bus.Out_ack;
  assign w_pop       = w_beat_xfer && w_last;
  assign w_push      = bus.Psum_rdy && bus.Psum_ack;

  // Ack is held low during reset so nothing is taken while the pointers are being cleared.
  assign bus.Psum_ack = i_rst && bus.Psum_rdy && !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.i_Psum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_beat_xfer) begin
        r_beat <= w_last ? '0 : r_beat + BW'(1);
      end
    end
  end

  // Empty FIFO presents zeros so the lanes never carry uninitialized storage.
  assign w_head = w_nonempty ? r_mem[r_rd_ptr[AW-1:0]] : '0;

  for (genvar g = 0; g < OUTN; g++) begin : g_lane
    logic [IW-1:0] w_idx;
    assign w_idx = IW'(int'(r_beat) * OUTN + g);
    psum_quant u_quant (
      .i_psum  (w_head[w_idx]),
      .i_qconf (bus.i_qconf),
      .o_out   (w_out[g])
    );
  end

  assign bus.o_Out   = w_out;
  assign bus.Out_rdy = w_nonempty;
  assign bus.o_beat  = r_beat;
  assign bus.o_last  = w_last;
  assign bus.o_count = r_count;
  assign bus.o_busy  = w_nonempty || bus.Psum_rdy;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: constant tables, corner sequences and a vector scoreboard.
module tb_psum_drain;
  import psum_drain_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_drain_if bus();

  psum_drain dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  psum_vec_t sb[$];
  int m_beat = 0;
  int vec_done = 0;

  typedef struct {
    int  p[4];
    int  sh;
    bit  relu;
    int  e[4];
  } qvec_t;
  qvec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DWD-1:0] qmodel(input logic [PSUMDWD-1:0] p, input QuantConf q);
    longint v;
    longint r;
    longint hi;
    v = longint'($signed(p));
    if (q.relu && v < 0) v = 0;
    if (q.shift == 0) r = v;
    else r = (v + (longint'(1) << (int'(q.shift) - 1))) >>> int'(q.shift);
    hi = (longint'(1) << (DWD - 1)) - 1;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return r[DWD-1:0];
  endfunction

  function automatic out_beat_t exp_beat(input psum_vec_t v, input int b, input QuantConf q);
    out_beat_t e;
    for (int k = 0; k < OUTN; k++) e[k] = qmodel(v[b*OUTN + k], q);
    return e;
  endfunction

  // Scoreboard monitor: vectors queued on input handshake, beats checked against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count", 64'(bus.o_count), 64'(sb.size()));
      check("out_rdy", 64'(bus.Out_rdy), 64'(sb.size() != 0));
      check("psum_ack", 64'(bus.Psum_ack), 64'(bus.Psum_rdy && sb.size() != DEPTH));
      check("busy", 64'(bus.o_busy), 64'(sb.size() != 0 || bus.Psum_rdy));
      if (bus.Out_rdy && sb.size() != 0) begin
        check("beat_idx", 64'(bus.o_beat), 64'(m_beat));
        check("last", 64'(bus.o_last), 64'(m_beat == BEATS - 1));
        check("lanes", 64'(bus.o_Out), 64'(exp_beat(sb[0], m_beat, bus.i_qconf)));
      end
      if (bus.Out_rdy && bus.Out_ack) begin
        if (sb.size() == 0) begin
          check("dup_beat", 64'(1), 64'(0));
        end else if (m_beat == BEATS - 1) begin
          void'(sb.pop_front());
          m_beat = 0;
          vec_done++;
        end else begin
          m_beat++;
        end
      end
      if (bus.Psum_rdy && bus.Psum_ack) sb.push_back(bus.i_Psum);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input psum_vec_t v);
    bit got;
    got = 1'b0;
    bus.i_Psum = v;
    bus.Psum_rdy = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = bus.Psum_ack;
    end
    if (!got) check("push_timeout", 64'(0), 64'(1));
    tick();
    bus.Psum_rdy = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      if (sb.size() == 0 && !bus.Out_rdy) done = 1'b1;
      else tick();
    end
    if (!done) check("drain_timeout", 64'(0), 64'(1));
  endtask

  function automatic psum_vec_t rand_vec();
    psum_vec_t v;
    int t;
    for (int i = 0; i < PEROW; i++) begin
      t = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 511)) - 256;
      v[i] = t[PSUMDWD-1:0];
    end
    return v;
  endfunction

  task automatic set_tbl(input int i, input int p0, input int p1, input int p2, input int p3,
                         input int sh, input bit relu,
                         input int e0, input int e1, input int e2, input int e3);
    tbl[i].p[0] = p0; tbl[i].p[1] = p1; tbl[i].p[2] = p2; tbl[i].p[3] = p3;
    tbl[i].sh = sh; tbl[i].relu = relu;
    tbl[i].e[0] = e0; tbl[i].e[1] = e1; tbl[i].e[2] = e2; tbl[i].e[3] = e3;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    psum_vec_t v;
    out_beat_t e;
    int t;
    int sent;
    int cyc;
    int done0;
    bit acc;

    set_tbl(0, 5, -5, 6, -6, 1, 1'b0, 3, -2, 3, -3);
    set_tbl(1, 1000, -1000, 0, 127, 2, 1'b0, 127, -128, 0, 32);
    set_tbl(2, -7, 7, -1, 300, 0, 1'b1, 0, 7, 0, 127);
    set_tbl(3, 127, 128, -128, -129, 0, 1'b0, 127, 127, -128, -128);
    set_tbl(4, -8, -9, 8, 23, 4, 1'b0, 0, -1, 1, 1);
    set_tbl(5, 8388607, -8388608, 4194304, -4194305, 23, 1'b0, 1, -1, 1, -1);

    bus.Psum_rdy = 1'b1;
    bus.i_Psum = '0;
    bus.i_qconf = '0;
    bus.Out_ack = 1'b0;
    #1;
    check("rst_psum_ack", 64'(bus.Psum_ack), 64'(0));
    check("rst_out_rdy", 64'(bus.Out_rdy), 64'(0));
    check("rst_last", 64'(bus.o_last), 64'(0));
    check("rst_beat", 64'(bus.o_beat), 64'(0));
    check("rst_count", 64'(bus.o_count), 64'(0));
    check("rst_out_known", 64'($isunknown(bus.o_Out)), 64'(0));
    bus.Psum_rdy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single vector p[i]=i drains in four back-to-back beats.
    bus.Out_ack = 1'b1;
    for (int i = 0; i < PEROW; i++) v[i] = PSUMDWD'(i);
    push_vec(v);
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      for (int k = 0; k < OUTN; k++) e[k] = DWD'(b * OUTN + k);
      if (b == 0) check("single_count1", 64'(bus.o_count), 64'(1));
      check("single_beat", 64'(bus.o_beat), 64'(b));
      check("single_last", 64'(bus.o_last), 64'(b == BEATS - 1));
      check("single_lanes", 64'(bus.o_Out), 64'(e));
    end
    @(negedge clk);
    check("single_count0", 64'(bus.o_count), 64'(0));
    tick();

    // Rounding, saturation and ReLU constants on lanes 0..3.
    bus.Out_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = '0;
      for (int k = 0; k < 4; k++) begin
        t = tbl[i].p[k];
        v[k] = t[PSUMDWD-1:0];
      end
      bus.i_qconf.shift = SHW'(tbl[i].sh);
      bus.i_qconf.relu = tbl[i].relu;
      push_vec(v);
      @(negedge clk);
      for (int k = 0; k < OUTN; k++) begin
        t = tbl[i].e[k];
        e[k] = t[DWD-1:0];
      end
      check($sformatf("quant_tbl%0d", i), 64'(bus.o_Out), 64'(e));
      tick();
      bus.Out_ack = 1'b1;
      wait_drain(50);
      bus.Out_ack = 1'b0;
    end

    // Backpressure: four vectors fill the FIFO, the fifth is refused.
    bus.i_qconf.shift = SHW'(3);
    bus.i_qconf.relu = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_Psum = rand_vec();
      bus.Psum_rdy = 1'b1;
      @(negedge clk);
      check($sformatf("bp_ack%0d", i), 64'(bus.Psum_ack), 64'(i < DEPTH));
      if (i == 4) check("bp_count", 64'(bus.o_count), 64'(DEPTH));
      if (i < 4) tick();
    end
    tick();
    bus.Out_ack = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.Psum_rdy && bus.Psum_ack) acc = 1'b1;
      tick();
      if (acc) bus.Psum_rdy = 1'b0;
      if (acc && sb.size() == 0 && !bus.Out_rdy) break;
    end
    check("bp_drained", 64'(acc && sb.size() == 0), 64'(1));
    bus.Out_ack = 1'b0;

    // Full with a last-beat pop in the same cycle: no push until the next cycle.
    for (int i = 0; i < DEPTH; i++) push_vec(rand_vec());
    bus.i_Psum = rand_vec();
    bus.Psum_rdy = 1'b1;
    @(negedge clk);
    check("full_ack", 64'(bus.Psum_ack), 64'(0));
    check("full_count", 64'(bus.o_count), 64'(DEPTH));
    tick();
    bus.Out_ack = 1'b1;
    repeat (BEATS) @(negedge clk);
    check("fullpop_last", 64'(bus.o_last), 64'(1));
    check("fullpop_ack", 64'(bus.Psum_ack), 64'(0));
    check("fullpop_count", 64'(bus.o_count), 64'(DEPTH));
    tick();
    bus.Out_ack = 1'b0;
    @(negedge clk);
    check("afterpop_count", 64'(bus.o_count), 64'(DEPTH - 1));
    check("afterpop_ack", 64'(bus.Psum_ack), 64'(1));
    tick();
    bus.Psum_rdy = 1'b0;
    @(negedge clk);
    check("refill_count", 64'(bus.o_count), 64'(DEPTH));
    tick();
    bus.Out_ack = 1'b1;
    wait_drain(100);

    // Random throttling on both sides with live config changes.
    done0 = vec_done;
    sent = 0;
    cyc = 0;
    bus.Psum_rdy = 1'b0;
    while (sent < 200 && cyc < 20000) begin
      @(negedge clk);
      acc = bus.Psum_rdy && bus.Psum_ack;
      tick();
      cyc++;
      if (acc) sent++;
      if (!bus.Psum_rdy || acc) begin
        if (sent < 200 && $urandom_range(0, 3) != 0) begin
          bus.i_Psum = rand_vec();
          bus.Psum_rdy = 1'b1;
        end else begin
          bus.Psum_rdy = 1'b0;
        end
      end
      bus.Out_ack = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.i_qconf.shift = SHW'($urandom_range(0, PSUMDWD - 1));
        bus.i_qconf.relu = $urandom_range(0, 1) != 0;
      end
    end
    check("rand_sent", 64'(sent), 64'(200));
    bus.Psum_rdy = 1'b0;
    bus.Out_ack = 1'b1;
    wait_drain(1000);
    check("rand_vectors_out", 64'(vec_done - done0), 64'(200));

    // Asynchronous reset mid-vector (beat 2, three vectors held).
    bus.Out_ack = 1'b0;
    bus.i_qconf = '0;
    for (int i = 0; i < 3; i++) push_vec(rand_vec());
    bus.Out_ack = 1'b1;
    repeat (2) tick();
    bus.Out_ack = 1'b0;
    @(negedge clk);
    check("pre_rst_beat", 64'(bus.o_beat), 64'(2));
    check("pre_rst_count", 64'(bus.o_count), 64'(3));
    #2;
    bus.i_Psum = rand_vec();
    bus.Psum_rdy = 1'b1;
    rst_n = 1'b0;
    sb.delete();
    m_beat = 0;
    #1;
    check("mid_rst_out_rdy", 64'(bus.Out_rdy), 64'(0));
    check("mid_rst_psum_ack", 64'(bus.Psum_ack), 64'(0));
    check("mid_rst_last", 64'(bus.o_last), 64'(0));
    check("mid_rst_count", 64'(bus.o_count), 64'(0));
    check("mid_rst_beat", 64'(bus.o_beat), 64'(0));
    repeat (2) tick();
    for (int i = 0; i < PEROW; i++) v[i] = PSUMDWD'(100 + i);
    rst_n = 1'b1;
    bus.Out_ack = 1'b1;
    push_vec(v);
    @(negedge clk);
    for (int k = 0; k < OUTN; k++) e[k] = DWD'(100 + k);
    check("post_rst_beat", 64'(bus.o_beat), 64'(0));
    check("post_rst_lanes", 64'(bus.o_Out), 64'(e));
    tick();
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
